ccu_ctrl_mu_arbiter: RTL and testbench

//  Shares the single CCU memory-unit request port (mu_req/mu_gnt/mu_op/holder/first_responder)

---
 rtl/ccu_ctrl_mu_arbiter.sv | 109 ++++++++++
 tb/tb_ccu_ctrl_mu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ccu_ctrl_mu_arbiter.sv
// ccu_ctrl_mu_arbiter: round-robin share of the CCU memory-unit request port with AMO lock and watchdog
// Ports: clk_i/rst_i clock and async active-high reset; req_i/op_i/amo_i/holder_i/first_responder_i
// per-requester request and payload; gnt_o one-hot handshake grant; mu_req_o/mu_op_o/holder_o/
// first_responder_o/mu_gnt_i memory-unit port; amo_done_i ends an AMO lock; busy_o/locked_o state
// flags; lock_timeout_o sticky watchdog flag.
module ccu_ctrl_mu_arbiter #(
  parameter int unsigned NoReq       = 4,
  parameter int unsigned NoMstPorts  = 4,
  parameter int unsigned LockTimeout = 1024,
  parameter type         slv_req_t   = logic,
  parameter type         mu_op_e     = logic [1:0],
  localparam int unsigned MstIdxBits = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NoReq-1:0]      req_i,
  input  mu_op_e                op_i [NoReq],
  input  logic [NoReq-1:0]      amo_i,
  input  slv_req_t              holder_i [NoReq],
  input  logic [MstIdxBits-1:0] first_responder_i [NoReq],
  output logic [NoReq-1:0]      gnt_o,
  output logic                  mu_req_o,
  output mu_op_e                mu_op_o,
  output slv_req_t              holder_o,
  output logic [MstIdxBits-1:0] first_responder_o,
  input  logic                  mu_gnt_i,
  input  logic                  amo_done_i,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  lock_timeout_o
);
  localparam int unsigned IdxW = $clog2(NoReq);
  localparam int unsigned CntW = $clog2(LockTimeout);
  localparam logic [CntW-1:0] CntMax = CntW'(LockTimeout - 1);
  typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick, j;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic lock_timeout_d;
  // Scan from the farthest offset down so the nearest set index at/after rr_ptr_q wins.
  always_comb begin
    pick = sel_q;
    j    = '0;
    for (int i = NoReq - 1; i >= 0; i--) begin
      j = IdxW'((int'(rr_ptr_q) + i) % NoReq);
      if (req_i[j]) pick = j;
    end
  end
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    rr_ptr_d       = rr_ptr_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = lock_timeout_o;
    mu_req_o       = 1'b0;
    gnt_o          = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          sel_d   = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        mu_req_o = req_i[sel_q];
        if (!req_i[sel_q]) begin
          state_d = IDLE;
        end else if (mu_gnt_i) begin
          gnt_o[sel_q] = 1'b1;
          rr_ptr_d     = (sel_q == IdxW'(NoReq - 1)) ? '0 : sel_q + 1'b1;
          lock_cnt_d   = '0;
          state_d      = amo_i[sel_q] ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        lock_cnt_d = (lock_cnt_q == CntMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
        if (amo_done_i) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CntMax) begin
          state_d        = IDLE;
          lock_cnt_d     = '0;
          lock_timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      rr_ptr_q       <= '0;
      lock_cnt_q     <= '0;
      lock_timeout_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_o <= lock_timeout_d;
    end
  end
  assign mu_op_o           = op_i[sel_q];
  assign holder_o          = holder_i[sel_q];
  assign first_responder_o = first_responder_i[sel_q];
  assign busy_o            = state_q != IDLE;
  assign locked_o          = state_q == LOCKED;
endmodule

// File: tb/tb_ccu_ctrl_mu_arbiter.sv
// tb_ccu_ctrl_mu_arbiter: directed scenarios plus randomized scoreboard check of the mu arbiter
module tb_ccu_ctrl_mu_arbiter;
  localparam int N  = 4;
  localparam int LT = 16;
  typedef logic [2:0] op_t;
  typedef logic [7:0] hold_t;
  typedef struct {
    int         idx;
    op_t        op;
    hold_t      h;
    logic [1:0] f;
    logic       a;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req, amo, gnt;
  op_t op [N];
  hold_t hold [N];
  logic [1:0] fr [N];
  logic mu_req, mu_gnt, amo_done, busy, locked, lto;
  op_t mu_op;
  hold_t mu_hold;
  logic [1:0] mu_fr;
  int total = 0;
  int bad = 0;
  bit chk_on = 0;
  exp_t q[$];
  exp_t e;
  int ptr, lcnt, w;
  bit lock_m, to_m, prev_mr, amo_g;
  logic [N-1:0] prev_req, g;
  ccu_ctrl_mu_arbiter #(
    .NoReq(N), .NoMstPorts(4), .LockTimeout(LT), .slv_req_t(hold_t), .mu_op_e(op_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .amo_i(amo), .holder_i(hold),
    .first_responder_i(fr), .gnt_o(gnt), .mu_req_o(mu_req), .mu_op_o(mu_op), .holder_o(mu_hold),
    .first_responder_o(mu_fr), .mu_gnt_i(mu_gnt), .amo_done_i(amo_done), .busy_o(busy),
    .locked_o(locked), .lock_timeout_o(lto)
  );
  always #5 clk = ~clk;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(string nm, logic [N-1:0] eg, logic mr, logic b, logic l, logic t);
    #1;
    check({nm, "_gnt"}, 32'(gnt), 32'(eg));
    check({nm, "_mureq"}, 32'(mu_req), 32'(mr));
    check({nm, "_busy"}, 32'(busy), 32'(b));
    check({nm, "_locked"}, 32'(locked), 32'(l));
    check({nm, "_timeout"}, 32'(lto), 32'(t));
  endtask
  // Scoreboard monitor: offers are predicted from the requests seen in the selection cycle,
  // grants are popped and matched, and the lock/watchdog flags follow a cycle-count model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_locked", 32'(locked), 32'(lock_m));
      check("m_timeout", 32'(lto), 32'(to_m));
      check("m_onehot", 32'($onehot0(gnt)), 32'(1));
      amo_g = 0;
      if (mu_req && !prev_mr) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && prev_req[(ptr + k) % N]) w = (ptr + k) % N;
        check("m_offer_in_lock", 32'(lock_m), 32'(0));
        if (w < 0) check("m_spurious_offer", 32'(mu_req), 32'(0));
        else q.push_back('{w, op[w], hold[w], fr[w], amo[w]});
      end
      if (mu_req) begin
        if (q.size() == 0) check("m_offer_no_exp", 32'(mu_req), 32'(0));
        else begin
          check("m_op", 32'(mu_op), 32'(q[0].op));
          check("m_holder", 32'(mu_hold), 32'(q[0].h));
          check("m_fr", 32'(mu_fr), 32'(q[0].f));
        end
      end
      if (gnt != '0) begin
        if (q.size() == 0) check("m_gnt_no_exp", 32'(gnt), 32'(0));
        else begin
          e = q.pop_front();
          check("m_gnt_idx", 32'(gnt), 32'(4'(1) << e.idx));
          check("m_gnt_mu", 32'(mu_gnt), 32'(1));
          ptr = (e.idx + 1) % N;
          amo_g = e.a;
        end
      end
      if (lock_m) begin
        lcnt++;
        if (amo_done) lock_m = 0;
        else if (lcnt == LT) begin
          lock_m = 0;
          to_m = 1;
        end
      end
      if (amo_g) begin
        lock_m = 1;
        lcnt = 0;
      end
      prev_req = req;
      prev_mr = mu_req;
    end
  end
  initial begin
    req = '0;
    amo = '0;
    mu_gnt = 0;
    amo_done = 0;
    for (int i = 0; i < N; i++) begin
      op[i] = 3'(i + 1);
      hold[i] = 8'(8'hA0 + i);
      fr[i] = 2'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    ex("rst", 4'b0000, 0, 0, 0, 0);
    check("rst_op_idx0", 32'(mu_op), 32'(1));
    rst = 0;
    // 1: single requester, 1-cycle latency, then rr pointer at 3
    nxt(); req = 4'b0100; mu_gnt = 1; ex("t1_idle", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t1_offer", 4'b0100, 1, 1, 0, 0);
    check("t1_op", 32'(mu_op), 32'(3));
    check("t1_holder", 32'(mu_hold), 32'(8'hA2));
    check("t1_fr", 32'(mu_fr), 32'(2));
    nxt(); req = 4'b0000; ex("t1_after", 4'b0000, 0, 0, 0, 0);
    nxt(); req = 4'b1001; ex("t1_idle2", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t1_ptr3", 4'b1000, 1, 1, 0, 0);
    // 2: all requesting, grant order 0,1,2,3,0 every other cycle
    nxt(); req = 4'b1111; ex("t2_start", 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      nxt(); ex("t2_offer", 4'(1 << (k % 4)), 1, 1, 0, 0);
      nxt(); if (k == 4) req = 4'b0000; ex("t2_gap", 4'b0000, 0, 0, 0, 0);
    end
    // 3: AMO lock blocks further offers until amo_done
    nxt(); req = 4'b0010; amo = 4'b0010; ex("t3_idle", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t3_grant", 4'b0010, 1, 1, 0, 0);
    nxt(); req = 4'b0001; amo = 4'b0000; ex("t3_lock", 4'b0000, 0, 1, 1, 0);
    repeat (3) begin
      nxt(); ex("t3_hold", 4'b0000, 0, 1, 1, 0);
    end
    nxt(); amo_done = 1; ex("t3_done", 4'b0000, 0, 1, 1, 0);
    nxt(); amo_done = 0; ex("t3_unlock", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t3_offer0", 4'b0001, 1, 1, 0, 0);
    check("t3_op0", 32'(mu_op), 32'(1));
    nxt(); req = 4'b0000; ex("t3_end", 4'b0000, 0, 0, 0, 0);
    // 4: watchdog expiry after LT locked cycles, sticky flag
    nxt(); req = 4'b0010; amo = 4'b0010; ex("t4_idle", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t4_grant", 4'b0010, 1, 1, 0, 0);
    for (int k = 0; k < LT; k++) begin
      nxt();
      if (k == 0) begin
        req = 4'b0000;
        amo = 4'b0000;
      end
      ex("t4_lock", 4'b0000, 0, 1, 1, 0);
    end
    nxt(); ex("t4_expire", 4'b0000, 0, 0, 0, 1);
    repeat (3) nxt();
    ex("t4_sticky", 4'b0000, 0, 0, 0, 1);
    // 5: abort by dropping request, pointer unchanged
    nxt(); req = 4'b0100; mu_gnt = 0; ex("t5_idle", 4'b0000, 0, 0, 0, 1);
    nxt(); ex("t5_offer", 4'b0000, 1, 1, 0, 1);
    nxt(); req = 4'b0000; mu_gnt = 1; ex("t5_drop", 4'b0000, 0, 1, 0, 1);
    nxt(); req = 4'b1111; ex("t5_back_idle", 4'b0000, 0, 0, 0, 1);
    nxt(); ex("t5_ptr2", 4'b0100, 1, 1, 0, 1);
    // 6: async reset during LOCKED and during OFFER
    nxt(); req = 4'b1000; amo = 4'b1000; ex("t6_idle", 4'b0000, 0, 0, 0, 1);
    nxt(); ex("t6_grant", 4'b1000, 1, 1, 0, 1);
    nxt(); req = 4'b0000; amo = 4'b0000; ex("t6_lock", 4'b0000, 0, 1, 1, 1);
    #2 rst = 1;
    ex("t6_rst_lock", 4'b0000, 0, 0, 0, 0);
    rst = 0;
    nxt(); req = 4'b0001; mu_gnt = 0; ex("t6_idle2", 4'b0000, 0, 0, 0, 0);
    nxt(); ex("t6_offer", 4'b0000, 1, 1, 0, 0);
    rst = 1; mu_gnt = 1;
    ex("t6_rst_offer", 4'b0000, 0, 0, 0, 0);
    nxt(); req = 4'b0000; rst = 0;
    // Random phase against the scoreboard
    ptr = 0; lock_m = 0; to_m = 0; lcnt = 0; prev_mr = 0; prev_req = '0; q.delete();
    chk_on = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && g[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          op[i] = 3'($urandom);
          hold[i] = 8'($urandom);
          fr[i] = 2'($urandom);
          amo[i] = ($urandom_range(0, 3) == 0);
          req[i] = 1'b1;
        end
      end
      mu_gnt = ($urandom_range(0, 2) != 0);
      amo_done = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
